serial_addsub: RTL and testbench

Bit-serial, parametrised-width adder/subtractor. A single full-adder cell built from NAND primitives is reused once per bit, with a registered carry between cycles. It processes two WIDTH-bit operands LSB-first and returns the result, the carry/borrow flag and a signed-overflow flag through a start/busy/done handshake. It is the area-minimal successor to the combinational NAND half/full adder cells, for datapaths where latency is cheap and gates are not.

---
 rtl/serial_addsub_pkg.sv | 13 +
 rtl/nand_fa_cell.sv | 26 ++
 rtl/serial_addsub.sv | 97 +++++++++
 tb/tb_serial_addsub.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/serial_addsub_pkg.sv
// Shared types for the bit-serial adder/subtractor: sequencer states and mode encodings.
package serial_addsub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

endpackage

// File: rtl/nand_fa_cell.sv
// One-bit full adder made only of nine 2-input NAND gates; the serial sequencer reuses it each bit.
module nand_fa_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    wire n1, n2, n3, x, n5, n6, n7, s_w, c_w;

    // First half adder forms a^b; the second folds in cin and shares n1/n5 for carry.
    nand g1 (n1, a, b);
    nand g2 (n2, a, n1);
    nand g3 (n3, b, n1);
    nand g4 (x, n2, n3);
    nand g5 (n5, x, cin);
    nand g6 (n6, x, n5);
    nand g7 (n7, cin, n5);
    nand g8 (s_w, n6, n7);
    nand g9 (c_w, n1, n5);

    assign sum  = s_w;
    assign cout = c_w;

endmodule

// File: rtl/serial_addsub.sv
// Bit-serial WIDTH-bit adder/subtractor: one NAND full-adder cell, LSB first, start/busy/done handshake.
module serial_addsub
    import serial_addsub_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             overflow
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    state_t           state, state_next;
    logic [WIDTH-1:0] a_sr, b_sr, acc, acc_next;
    logic [CNT_W-1:0] cnt;
    logic             c_reg, mode_q;
    logic             sum, cout, last;

    nand_fa_cell u_cell (
        .a    (a_sr[0]),
        .b    (b_sr[0]),
        .cin  (c_reg),
        .sum  (sum),
        .cout (cout)
    );

    assign last     = (cnt == CNT_W'(WIDTH - 1));
    // Sum enters at the MSB; the wide shift keeps this valid for WIDTH=1.
    assign acc_next = WIDTH'({sum, acc} >> 1);
    assign busy     = (state == RUN);
    assign done     = (state == DONE);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (last)  state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_sr     <= '0;
            b_sr     <= '0;
            acc      <= '0;
            cnt      <= '0;
            c_reg    <= 1'b0;
            mode_q   <= MODE_ADD;
            result   <= '0;
            carry    <= 1'b0;
            overflow <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        // Subtract as a + ~b + 1: the +1 rides in as the initial carry.
                        a_sr   <= a;
                        b_sr   <= (mode == MODE_SUB) ? ~b : b;
                        c_reg  <= mode;
                        mode_q <= mode;
                        cnt    <= '0;
                    end
                end
                RUN: begin
                    a_sr  <= a_sr >> 1;
                    b_sr  <= b_sr >> 1;
                    acc   <= acc_next;
                    c_reg <= cout;
                    cnt   <= cnt + 1'b1;
                    if (last) begin
                        result   <= acc_next;
                        carry    <= cout ^ mode_q;
                        overflow <= cout ^ c_reg;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_addsub.sv
// Scoreboard bench for serial_addsub: directed cases, random 8-bit ops and a WIDTH=1 instance.
module tb_serial_addsub;

    typedef struct {
        logic [63:0] res;
        logic        c;
        logic        ov;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       start8, mode8, busy8, done8, carry8, ov8;
    logic [7:0] a8, b8, result8;
    logic       start1, mode1, busy1, done1, carry1, ov1;
    logic [0:0] a1, b1, result1;

    int checks = 0;
    int passes = 0;
    exp_t q8[$];
    exp_t q1[$];
    logic prev8 = 1'b0;
    logic prev1 = 1'b0;

    always #5 clk = ~clk;

    serial_addsub #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .mode(mode8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .result(result8), .carry(carry8), .overflow(ov8)
    );

    serial_addsub #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .mode(mode1), .a(a1), .b(b1),
        .busy(busy1), .done(done1), .result(result1), .carry(carry1), .overflow(ov1)
    );

    // Reference: plain integer arithmetic on unsigned and signed interpretations.
    function automatic exp_t model(input int w, input logic m, input longint ua, input longint ub);
        exp_t   e;
        longint full, sa, sb, sr, half, span;
        span = longint'(1) << w;
        half = span / 2;
        sa   = (ua >= half) ? ua - span : ua;
        sb   = (ub >= half) ? ub - span : ub;
        if (m) begin
            full = ua - ub;
            e.c  = (ua < ub);
            sr   = sa - sb;
        end else begin
            full = ua + ub;
            e.c  = (full >= span);
            sr   = sa + sb;
        end
        e.ov  = (sr < -half) || (sr > half - 1);
        e.res = 64'(full & (span - 1));
        return e;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act === req) passes++;
        else $display("FAIL %s: got %0h, required %0h", name, act, req);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (prev8) chk("done8_single_cycle", 64'(done8), 64'd0);
        prev8 = done8;
        if (done8) begin
            if (q8.size() == 0) chk("done8_unexpected", 64'd1, 64'd0);
            else begin
                e = q8.pop_front();
                chk("result8", 64'(result8), e.res);
                chk("carry8", 64'(carry8), 64'(e.c));
                chk("overflow8", 64'(ov8), 64'(e.ov));
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (prev1) chk("done1_single_cycle", 64'(done1), 64'd0);
        prev1 = done1;
        if (done1) begin
            if (q1.size() == 0) chk("done1_unexpected", 64'd1, 64'd0);
            else begin
                e = q1.pop_front();
                chk("result1", 64'(result1), e.res);
                chk("carry1", 64'(carry1), 64'(e.c));
                chk("overflow1", 64'(ov1), 64'(e.ov));
            end
        end
    end

    task automatic run8(input logic m, input logic [7:0] x, input logic [7:0] y, input bit glitch);
        exp_t e;
        int   lat;
        bit   seen;
        @(negedge clk);
        start8 = 1'b1; mode8 = m; a8 = x; b8 = y;
        e = model(8, m, longint'(x), longint'(y));
        q8.push_back(e);
        @(posedge clk);
        #1;
        start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); mode8 = ~m;
        lat = 0; seen = 0;
        for (int i = 1; i <= 40 && !seen; i++) begin
            @(negedge clk);
            start8 = glitch && (i == 3);
            if (glitch && i == 3) begin a8 = 8'hAA; b8 = 8'h55; mode8 = 1'b1; end
            if (i == 1) chk("busy8_in_run", 64'(busy8), 64'd1);
            if (done8) begin
                seen = 1; lat = i;
                chk("busy8_in_done", 64'(busy8), 64'd0);
            end
        end
        chk("latency8", 64'(lat), 64'd9);
        if (glitch) begin
            start8 = 1'b1;
            @(negedge clk);
            start8 = 1'b0;
            chk("start_in_done_ignored", 64'(busy8), 64'd0);
            chk("result8_hold", 64'(result8), e.res);
        end
    endtask

    task automatic run1(input logic m, input logic x, input logic y);
        int lat;
        bit seen;
        @(negedge clk);
        start1 = 1'b1; mode1 = m; a1 = x; b1 = y;
        q1.push_back(model(1, m, longint'(x), longint'(y)));
        @(posedge clk);
        #1;
        start1 = 1'b0; a1 = ~x; b1 = ~y;
        lat = 0; seen = 0;
        for (int i = 1; i <= 20 && !seen; i++) begin
            @(negedge clk);
            if (i == 1) chk("busy1_in_run", 64'(busy1), 64'd1);
            if (done1) begin seen = 1; lat = i; end
        end
        chk("latency1", 64'(lat), 64'd2);
    endtask

    initial begin
        rst = 1'b1;
        start8 = 0; mode8 = 0; a8 = 0; b8 = 0;
        start1 = 0; mode1 = 0; a1 = 0; b1 = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy8", 64'(busy8), 64'd0);
        chk("rst_done8", 64'(done8), 64'd0);
        chk("rst_result8", 64'(result8), 64'd0);
        chk("rst_carry8", 64'(carry8), 64'd0);
        chk("rst_overflow8", 64'(ov8), 64'd0);
        chk("rst_busy1", 64'(busy1), 64'd0);
        rst = 1'b0;

        run8(1'b0, 8'h5A, 8'h3C, 0);
        run8(1'b1, 8'h10, 8'h20, 0);
        run8(1'b0, 8'hFF, 8'h01, 0);
        run8(1'b1, 8'h80, 8'h01, 0);
        run8(1'b0, 8'h12, 8'h34, 1);

        // Abort an operation mid-RUN with reset; no done may follow.
        @(negedge clk);
        start8 = 1'b1; mode8 = 1'b0; a8 = 8'h77; b8 = 8'h11;
        @(posedge clk);
        #1;
        start8 = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midrun_rst_busy", 64'(busy8), 64'd0);
        chk("midrun_rst_done", 64'(done8), 64'd0);
        chk("midrun_rst_result", 64'(result8), 64'd0);
        chk("midrun_rst_carry", 64'(carry8), 64'd0);
        chk("midrun_rst_overflow", 64'(ov8), 64'd0);
        repeat (14) @(negedge clk);
        run8(1'b0, 8'h01, 8'h01, 0);

        for (int n = 0; n < 1500; n++)
            run8(1'($urandom), 8'($urandom), 8'($urandom), 0);

        for (int n = 0; n < 8; n++)
            run1(n[2], n[1], n[0]);
        run1(1'b0, 1'b1, 1'b1);

        repeat (3) @(negedge clk);
        chk("q8_drained", 64'(q8.size()), 64'd0);
        chk("q1_drained", 64'(q1.size()), 64'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
